// File: rtl/cond_eval_pipe.sv
// Two-stage lt/eq/gt condition evaluator on x or x-y; result 2 cycles after accept.
// Backpressure: a stalled output holds both stages, and in_ready falls combinationally once the pipe is full.
module cond_eval_pipe #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 1,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [TAG_W-1:0] out_tag,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] taken_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_neg_q, s1_neg_d;
  logic             s1_zero_q, s1_zero_d;
  logic [2:0]       s1_mask_q, s1_mask_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic             taken_q, taken_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_en, s2_en, accept;
  logic [WIDTH:0]   ext_x, ext_y, diff;

  assign s2_en    = ~s2_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = rst_n & s1_en;
  assign accept   = in_valid & in_ready;

  // One extra bit of headroom makes x-y exact for both signednesses.
  always_comb begin
    ext_x = (SIGNED != 0) ? {x[WIDTH-1], x} : {1'b0, x};
    ext_y = (SIGNED != 0) ? {y[WIDTH-1], y} : {1'b0, y};
    diff  = ext_x - (mode ? ext_y : '0);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_neg_d   = s1_neg_q;
    s1_zero_d  = s1_zero_q;
    s1_mask_d  = s1_mask_q;
    s1_tag_d   = s1_tag_q;
    if (s1_en) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_neg_d  = diff[WIDTH];
      s1_zero_d = (diff == '0);
      s1_mask_d = {lt, eq, gt};
      s1_tag_d  = in_tag;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    taken_d    = taken_q;
    out_tag_d  = out_tag_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      taken_d    = (s1_mask_q[2] & s1_neg_q) |
                   (s1_mask_q[1] & s1_zero_q) |
                   (s1_mask_q[0] & ~s1_neg_q & ~s1_zero_q);
      out_tag_d  = s1_tag_q;
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && taken_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mask_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      out_tag_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_neg_q   <= s1_neg_d;
      s1_zero_q  <= s1_zero_d;
      s1_mask_q  <= s1_mask_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      taken_q    <= taken_d;
      out_tag_q  <= out_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign taken     = taken_q;
  assign out_tag   = out_tag_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_cond_eval_pipe.sv
// Bench for cond_eval_pipe: signed, unsigned and 2-bit-counter variants driven by shared stimulus.
module tb_cond_eval_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, lt, eq, gt, mode, out_ready, cnt_clr;
  logic [15:0] x, y;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, taken;
  logic [3:0]  out_tag;
  logic [15:0] taken_cnt;
  logic        in_ready_u, out_valid_u, taken_u;
  logic [3:0]  out_tag_u;
  logic [15:0] taken_cnt_u;
  logic        in_ready_c, out_valid_c, taken_c;
  logic [3:0]  out_tag_c;
  logic [1:0]  taken_cnt_c;

  always #5 clk = ~clk;

  cond_eval_pipe #(.WIDTH(16), .SIGNED(1), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .lt(lt), .eq(eq), .gt(gt), .mode(mode), .x(x), .y(y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .out_tag(out_tag),
    .cnt_clr(cnt_clr), .taken_cnt(taken_cnt));

  cond_eval_pipe #(.WIDTH(16), .SIGNED(0), .TAG_W(4), .CNT_W(16)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .lt(lt), .eq(eq), .gt(gt), .mode(mode), .x(x), .y(y), .in_tag(in_tag),
    .out_valid(out_valid_u), .out_ready(out_ready), .taken(taken_u), .out_tag(out_tag_u),
    .cnt_clr(cnt_clr), .taken_cnt(taken_cnt_u));

  cond_eval_pipe #(.WIDTH(16), .SIGNED(1), .TAG_W(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .lt(lt), .eq(eq), .gt(gt), .mode(mode), .x(x), .y(y), .in_tag(in_tag),
    .out_valid(out_valid_c), .out_ready(out_ready), .taken(taken_c), .out_tag(out_tag_c),
    .cnt_clr(cnt_clr), .taken_cnt(taken_cnt_c));

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, no bit-level tricks.
  function automatic bit exp_taken(input bit sgn, input logic [2:0] m, input logic md,
                                   input logic [15:0] a, input logic [15:0] b);
    longint da, db, d;
    da = sgn ? longint'($signed(a)) : longint'({48'b0, a});
    db = sgn ? longint'($signed(b)) : longint'({48'b0, b});
    d  = da - (md ? db : 64'sd0);
    return (m[2] && d < 0) || (m[1] && d == 0) || (m[0] && d > 0);
  endfunction

  typedef struct {
    int         acc;
    logic [3:0] tag;
    bit         ts;
    bit         tu;
  } ent_t;

  ent_t       q[$];
  int         cyc = 0;
  int         m_cnt = 0, m_cnt_u = 0, m_cnt_c = 0;
  int         n_out = 0;
  logic [3:0] last_tag = 4'h0;

  // Each negedge: compare outputs against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    bit   ev;
    ent_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0; m_cnt_u = 0; m_cnt_c = 0;
      chk("rst_out_valid", {out_valid, out_valid_u, out_valid_c}, 0);
      chk("rst_in_ready", {in_ready, in_ready_u, in_ready_c}, 0);
      chk("rst_taken_tag", {taken, out_tag}, 0);
      chk("rst_cnt", {taken_cnt, taken_cnt_u, taken_cnt_c}, 0);
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("out_valid", out_valid, ev);
      chk("out_valid_u", out_valid_u, ev);
      chk("out_valid_c", out_valid_c, ev);
      chk("in_ready", {in_ready, in_ready_u, in_ready_c},
          {3{(q.size() < 2) || (ev && out_ready)}});
      if (ev) begin
        chk("out_tag", {out_tag, out_tag_u, out_tag_c}, {3{q[0].tag}});
        chk("taken_s", taken, q[0].ts);
        chk("taken_u", taken_u, q[0].tu);
        chk("taken_c", taken_c, q[0].ts);
      end
      chk("cnt", taken_cnt, m_cnt);
      chk("cnt_u", taken_cnt_u, m_cnt_u);
      chk("cnt_c", taken_cnt_c, m_cnt_c);
      if (ev && out_ready) begin
        if (q[0].ts && m_cnt < 65535) m_cnt++;
        if (q[0].tu && m_cnt_u < 65535) m_cnt_u++;
        if (q[0].ts && m_cnt_c < 3) m_cnt_c++;
        n_out++;
        last_tag = q[0].tag;
        void'(q.pop_front());
      end
      if (cnt_clr) begin
        m_cnt = 0; m_cnt_u = 0; m_cnt_c = 0;
      end
      if (in_valid && in_ready) begin
        e.acc = cyc;
        e.tag = in_tag;
        e.ts  = exp_taken(1'b1, {lt, eq, gt}, mode, x, y);
        e.tu  = exp_taken(1'b0, {lt, eq, gt}, mode, x, y);
        q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] m, input logic md, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] t);
    bit ok;
    ok = 0;
    {lt, eq, gt} = m; mode = md; x = a; y = b; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] xv [3] = '{16'hFFFF, 16'h0000, 16'h0001};
  int          base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; {lt, eq, gt} = 3'b000; mode = 1'b0;
    x = '0; y = '0; in_tag = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // 1: latency from accept to out_valid is exactly two cycles
    idle(1);
    {lt, eq, gt} = 3'b001; mode = 1'b0; x = 16'd5; in_tag = 4'd1; in_valid = 1'b1;
    @(negedge clk); chk("t1_in_ready", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("t1_valid_cyc1", out_valid, 0);
    @(negedge clk); chk("t1_valid_cyc2", out_valid, 1);
    chk("t1_taken", taken, 1);
    chk("t1_tag", out_tag, 1);
    idle(2);

    // 2: 0x8000 - 1 is -32769 signed (lt taken), 32767 unsigned (lt not taken)
    send(3'b100, 1'b1, 16'h8000, 16'h0001, 4'd2);
    @(negedge clk);
    @(negedge clk);
    chk("t2_valid", out_valid, 1);
    chk("t2_signed_taken", taken, 1);
    chk("t2_unsigned_taken", taken_u, 0);
    idle(2);

    // 3: back-to-back tags, then a 3-cycle output stall
    for (int t = 0; t < 8; t++) send(3'b010, 1'b1, 16'(t), 16'd2, 4'(t));
    out_ready = 1'b0;
    {lt, eq, gt} = 3'b001; mode = 1'b0; x = 16'd3; in_tag = 4'd8; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_in_ready", in_ready, 0);
      chk("t3_stall_valid", out_valid, 1);
      chk("t3_stall_tag", out_tag, 6);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'b001, 1'b0, 16'd3, 16'd0, 4'd8);
    idle(4);
    chk("t3_drained", q.size(), 0);
    chk("t3_last_tag", last_tag, 8);

    // 4: every mask against -1, 0, +1
    for (int m = 0; m < 8; m++)
      for (int k = 0; k < 3; k++)
        send(3'(m), 1'b0, xv[k], 16'h1234, 4'(m * 3 + k));
    idle(4);
    chk("t4_drained", q.size(), 0);

    // 5: 2-bit counter saturates, clear beats a same-cycle taken consume
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    chk("t5_cleared", taken_cnt_c, 0);
    for (int t = 0; t < 5; t++) send(3'b111, 1'b0, 16'd7, 16'd0, 4'(t));
    idle(4);
    chk("t5_sat", taken_cnt_c, 3);
    chk("t5_cnt16", taken_cnt, 5);
    send(3'b111, 1'b0, 16'd7, 16'd0, 4'd10);
    idle(1);
    chk("t5_clr_valid", {out_valid, taken}, 2'b11);
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    chk("t5_clr_wins_c", taken_cnt_c, 0);
    chk("t5_clr_wins", taken_cnt, 0);

    // 6: reset with two results in flight
    send(3'b111, 1'b0, 16'd1, 16'd0, 4'd1);
    idle(4);
    chk("t6_pre_cnt", taken_cnt, 1);
    send(3'b111, 1'b0, 16'd1, 16'd0, 4'd3);
    send(3'b111, 1'b0, 16'd1, 16'd0, 4'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_cnt", taken_cnt, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    idle(2);
    rst_n = 1'b1;
    base = n_out;
    send(3'b001, 1'b0, 16'd5, 16'd0, 4'd9);
    idle(4);
    chk("t6_one_result", n_out - base, 1);
    chk("t6_tag", last_tag, 9);
    chk("t6_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", nchk, nfail);
    $fatal(1);
  end

endmodule
